// File: rtl/vec_simd_pkg.sv
// Shared types and width helpers for the vector state register file and its transposer.
package vec_simd_pkg;

    typedef enum logic [1:0] {
        TR_IDLE = 2'd0,
        TR_XFER = 2'd1,
        TR_DONE = 2'd2
    } tr_state_e;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_LANES = 4;
    localparam int DEF_EW    = 8;

    // Row-address width; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Element-index width; never narrower than one bit.
    function automatic int elem_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vec_state_transposer.sv
// Transpose sequencer: snapshots a LANES x LANES block, then writes one transposed row per cycle.
module vec_state_transposer
    import vec_simd_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int LANES = DEF_LANES,
    parameter  int EW    = DEF_EW,
    localparam int AW    = addr_width(DEPTH),
    localparam int CW    = elem_width(LANES),
    localparam int W     = LANES * EW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tr_start,
    input  logic [AW-1:0]      tr_base,
    input  logic [LANES*W-1:0] snap_rows,
    output logic               start_acc,
    output logic               xfer_we,
    output logic [AW-1:0]      xfer_addr,
    output logic [W-1:0]       xfer_data,
    output tr_state_e          state_dbg
);

    tr_state_e       state_q;
    tr_state_e       state_d;
    logic [W-1:0]    shadow_q [LANES];
    logic [AW-1:0]   base_q;
    logic [CW-1:0]   k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TR_IDLE: if (tr_start) state_d = TR_XFER;
            TR_XFER: if (k_q == CW'(LANES - 1)) state_d = TR_DONE;
            TR_DONE: state_d = TR_IDLE;
            default: state_d = TR_IDLE;
        endcase
    end

    // Row base+k of the result is column k of the snapshot; snapshot row j lands in element j.
    always_comb begin
        start_acc = !rst && (state_q == TR_IDLE) && tr_start;
        xfer_we   = !rst && (state_q == TR_XFER);
        xfer_addr = base_q + AW'(k_q);
        xfer_data = '0;
        for (int j = 0; j < LANES; j++) begin
            xfer_data[(LANES-1-j)*EW +: EW] = shadow_q[j][(LANES-1-int'(k_q))*EW +: EW];
        end
        state_dbg = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                shadow_q[i] <= '0;
            end
            base_q <= '0;
            k_q    <= '0;
        end else if (start_acc) begin
            for (int i = 0; i < LANES; i++) begin
                shadow_q[i] <= snap_rows[i*W +: W];
            end
            base_q <= tr_base;
            k_q    <= '0;
        end else if (state_q == TR_XFER) begin
            k_q <= k_q + 1'b1;
        end
    end

endmodule

// File: rtl/vec_state_regfile.sv
// Vector state register file with row/column access and an in-place block transpose engine.
module vec_state_regfile
    import vec_simd_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int LANES = DEF_LANES,
    parameter  int EW    = DEF_EW,
    localparam int AW    = addr_width(DEPTH),
    localparam int CW    = elem_width(LANES),
    localparam int W     = LANES * EW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    input  logic             col_read,
    input  logic [CW-1:0]    rd_col,
    input  logic             wr_en,
    input  logic             col_write,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CW-1:0]    wr_col,
    input  logic [LANES-1:0] wr_mask,
    input  logic [W-1:0]     wr_data,
    input  logic             tr_start,
    input  logic [AW-1:0]    tr_base,
    output logic [W-1:0]     rd_data1,
    output logic [W-1:0]     rd_data2,
    output logic             busy,
    output logic             done,
    output logic             wr_drop
);

    logic [W-1:0]       mem [DEPTH];
    logic [LANES*W-1:0] snap_rows;
    logic               start_acc;
    logic               xfer_we;
    logic [AW-1:0]      xfer_addr;
    logic [W-1:0]       xfer_data;
    tr_state_e          tr_state;
    logic [AW-1:0]      rd_row_addr;

    vec_state_transposer #(
        .DEPTH (DEPTH),
        .LANES (LANES),
        .EW    (EW)
    ) u_transposer (
        .clk       (clk),
        .rst       (rst),
        .tr_start  (tr_start),
        .tr_base   (tr_base),
        .snap_rows (snap_rows),
        .start_acc (start_acc),
        .xfer_we   (xfer_we),
        .xfer_addr (xfer_addr),
        .xfer_data (xfer_data),
        .state_dbg (tr_state)
    );

    always_comb begin
        snap_rows = '0;
        for (int i = 0; i < LANES; i++) begin
            snap_rows[i*W +: W] = mem[tr_base + AW'(i)];
        end
    end

    // External writes lose to the transposer on the accept edge and for the whole XFER phase.
    always_comb begin
        busy    = !rst && (tr_state == TR_XFER);
        done    = !rst && (tr_state == TR_DONE);
        wr_drop = !rst && wr_en && (start_acc || busy);
    end

    // Column reads gather element rd_col from LANES consecutive rows, base row in the MSBs.
    always_comb begin
        rd_data1    = '0;
        rd_data2    = '0;
        rd_row_addr = '0;
        if (col_read) begin
            for (int i = 0; i < LANES; i++) begin
                rd_row_addr = rd_addr1 + AW'(i);
                rd_data1[(LANES-1-i)*EW +: EW] = mem[rd_row_addr][(LANES-1-int'(rd_col))*EW +: EW];
            end
        end else begin
            rd_data1 = mem[rd_addr1];
            rd_data2 = mem[rd_addr2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (xfer_we) begin
            mem[xfer_addr] <= xfer_data;
        end else if (wr_en && !wr_drop) begin
            if (col_write) begin
                for (int i = 0; i < LANES; i++) begin
                    mem[wr_addr + AW'(i)][(LANES-1-int'(wr_col))*EW +: EW] <= wr_data[(LANES-1-i)*EW +: EW];
                end
            end else begin
                for (int e = 0; e < LANES; e++) begin
                    if (wr_mask[e]) begin
                        mem[wr_addr][(LANES-1-e)*EW +: EW] <= wr_data[(LANES-1-e)*EW +: EW];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_state_regfile.sv
// Directed bench for vec_state_regfile: row/column access, masked writes, transpose and reset.
module tb_vec_state_regfile;

    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic        col_read;
    logic [1:0]  rd_col;
    logic        wr_en;
    logic        col_write;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_col;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        tr_start;
    logic [3:0]  tr_base;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        busy;
    logic        done;
    logic        wr_drop;

    int n_cmp;
    int n_err;

    vec_state_regfile #(.DEPTH(16), .LANES(4), .EW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .col_read  (col_read),
        .rd_col    (rd_col),
        .wr_en     (wr_en),
        .col_write (col_write),
        .wr_addr   (wr_addr),
        .wr_col    (wr_col),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .tr_start  (tr_start),
        .tr_base   (tr_base),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .busy      (busy),
        .done      (done),
        .wr_drop   (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_row(input logic [3:0] a, output logic [31:0] d);
        col_read = 1'b0;
        rd_addr1 = a;
        #1;
        d = rd_data1;
    endtask

    task automatic write_row(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_en     = 1'b1;
        col_write = 1'b0;
        wr_addr   = a;
        wr_data   = d;
        wr_mask   = m;
        step();
        wr_en     = 1'b0;
    endtask

    task automatic load_block();
        write_row(4'd0, 32'h00010203, 4'hF);
        write_row(4'd1, 32'h04050607, 4'hF);
        write_row(4'd2, 32'h08090A0B, 4'hF);
        write_row(4'd3, 32'h0C0D0E0F, 4'hF);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hCAFEF00D; wr_mask = 4'hF;
        tr_start = 1'b1; tr_base = 4'd0;
        #1;
        n_cmp++;
        if (wr_drop !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got drop/busy/done %b%b%b, need 000", wr_drop, busy, done);
        end
        step();
        step();
        rst = 1'b0; wr_en = 1'b0; tr_start = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_start_ignored: got busy %b done %b, need 0 0", busy, done);
        end
        rd_row(4'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_write_ignored: got %h, need 00000000", d);
        end
        for (int r = 0; r < 16; r += 5) begin
            rd_row(r[3:0], d);
            n_cmp++;
            if (d !== 32'h0) begin
                n_err++;
                $display("FAIL reset_row%0d: got %h, need 00000000", r, d);
            end
        end
    endtask

    task automatic test_row_write();
        wr_en = 1'b1; col_write = 1'b0; wr_addr = 4'd5; wr_data = 32'hA1B2C3D4; wr_mask = 4'hF;
        col_read = 1'b0; rd_addr1 = 4'd5; rd_addr2 = 4'd6;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h0 || wr_drop !== 1'b0) begin
            n_err++;
            $display("FAIL row_no_bypass: got %h drop %b, need 00000000 drop 0", rd_data1, wr_drop);
        end
        step();
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'hA1B2C3D4) begin
            n_err++;
            $display("FAIL row_write_rd1: got %h, need a1b2c3d4", rd_data1);
        end
        n_cmp++;
        if (rd_data2 !== 32'h0) begin
            n_err++;
            $display("FAIL row_write_rd2: got %h, need 00000000", rd_data2);
        end
    endtask

    task automatic test_masked_write();
        logic [31:0] d;
        write_row(4'd2, 32'h11223344, 4'hF);
        // Element order e0..e3 = 0,1,0,1: only elements 1 and 3 are written.
        write_row(4'd2, 32'hFFFFFFFF, 4'b1010);
        rd_row(4'd2, d);
        n_cmp++;
        if (d !== 32'h11FF33FF) begin
            n_err++;
            $display("FAIL masked_write: got %h, need 11ff33ff", d);
        end
        write_row(4'd2, 32'h99999999, 4'h0);
        rd_row(4'd2, d);
        n_cmp++;
        if (d !== 32'h11FF33FF) begin
            n_err++;
            $display("FAIL zero_mask_write: got %h, need 11ff33ff", d);
        end
    endtask

    task automatic test_col_write();
        logic [31:0] d;
        logic [31:0] exp_rows [4];
        logic [3:0]  addrs [4];
        exp_rows[0] = 32'h0000DE00; exp_rows[1] = 32'h0000AD00;
        exp_rows[2] = 32'h0000BE00; exp_rows[3] = 32'h0000EF00;
        addrs[0] = 4'd14; addrs[1] = 4'd15; addrs[2] = 4'd0; addrs[3] = 4'd1;
        wr_en = 1'b1; col_write = 1'b1; wr_addr = 4'd14; wr_col = 2'd2;
        wr_data = 32'hDEADBEEF; wr_mask = 4'h0;
        step();
        wr_en = 1'b0; col_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_row(addrs[i], d);
            n_cmp++;
            if (d !== exp_rows[i]) begin
                n_err++;
                $display("FAIL col_write_row%0d: got %h, need %h", addrs[i], d, exp_rows[i]);
            end
        end
        col_read = 1'b1; rd_addr1 = 4'd14; rd_col = 2'd2; rd_addr2 = 4'd5;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'hDEADBEEF || rd_data2 !== 32'h0) begin
            n_err++;
            $display("FAIL col_read: got %h / %h, need deadbeef / 00000000", rd_data1, rd_data2);
        end
        col_read = 1'b0;
    endtask

    task automatic test_transpose();
        logic [31:0] d;
        logic [31:0] exp_rows [4];
        exp_rows[0] = 32'h0004080C; exp_rows[1] = 32'h0105090D;
        exp_rows[2] = 32'h02060A0E; exp_rows[3] = 32'h03070B0F;
        load_block();
        tr_base = 4'd0; tr_start = 1'b1;
        step();
        tr_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL tr_busy_c%0d: got busy %b done %b, need 1 0", c, busy, done);
            end
            if (c == 2) begin
                rd_row(4'd0, d);
                n_cmp++;
                if (d !== 32'h0004080C) begin
                    n_err++;
                    $display("FAIL tr_partial_row0: got %h, need 0004080c", d);
                end
                rd_row(4'd1, d);
                n_cmp++;
                if (d !== 32'h04050607) begin
                    n_err++;
                    $display("FAIL tr_partial_row1: got %h, need 04050607", d);
                end
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tr_done_c5: got done %b busy %b, need 1 0", done, busy);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tr_idle_after: got done %b busy %b, need 0 0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            rd_row(i[3:0], d);
            n_cmp++;
            if (d !== exp_rows[i]) begin
                n_err++;
                $display("FAIL tr_row%0d: got %h, need %h", i, d, exp_rows[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] exp_rows [4];
        exp_rows[0] = 32'h00010203; exp_rows[1] = 32'h04050607;
        exp_rows[2] = 32'h08090A0B; exp_rows[3] = 32'h0C0D0E0F;
        tr_base = 4'd0; tr_start = 1'b1;
        wr_en = 1'b1; col_write = 1'b0; wr_addr = 4'd8; wr_data = 32'h55555555; wr_mask = 4'hF;
        #1;
        n_cmp++;
        if (wr_drop !== 1'b1) begin
            n_err++;
            $display("FAIL drop_on_accept: got %b, need 1", wr_drop);
        end
        step();
        tr_start = 1'b0;
        wr_addr = 4'd9; wr_data = 32'h66666666;
        #1;
        n_cmp++;
        if (wr_drop !== 1'b1) begin
            n_err++;
            $display("FAIL drop_in_xfer: got %b, need 1", wr_drop);
        end
        step();
        wr_en = 1'b0;
        tr_start = 1'b1; tr_base = 4'd8;
        step();
        step();
        tr_start = 1'b0;
        step();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done: got %b, need 1", done);
        end
        step();
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_restart: got busy %b done %b, need 0 0", busy, done);
        end
        rd_row(4'd8, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL drop_row8: got %h, need 00000000", d);
        end
        rd_row(4'd9, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL drop_row9: got %h, need 00000000", d);
        end
        for (int i = 0; i < 4; i++) begin
            rd_row(i[3:0], d);
            n_cmp++;
            if (d !== exp_rows[i]) begin
                n_err++;
                $display("FAIL b2b_row%0d: got %h, need %h", i, d, exp_rows[i]);
            end
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic [31:0] d;
        int          done_seen;
        tr_base = 4'd0; tr_start = 1'b1;
        step();
        tr_start = 1'b0;
        step();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77777777; wr_mask = 4'hF;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
            n_err++;
            $display("FAIL rst_xfer_outputs: got busy/done/drop %b%b%b, need 000", busy, done, wr_drop);
        end
        step();
        rst = 1'b0; wr_en = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            step();
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_err++;
            $display("FAIL rst_xfer_no_done: got %0d active cycles, need 0", done_seen);
        end
        for (int r = 0; r < 16; r++) begin
            rd_row(r[3:0], d);
            n_cmp++;
            if (d !== 32'h0) begin
                n_err++;
                $display("FAIL rst_xfer_row%0d: got %h, need 00000000", r, d);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0; col_read = 1'b0; rd_col = '0;
        wr_en = 1'b0; col_write = 1'b0; wr_addr = '0; wr_col = '0; wr_mask = '0; wr_data = '0;
        tr_start = 1'b0; tr_base = '0;
        step();
        test_reset();
        test_row_write();
        test_masked_write();
        test_col_write();
        test_transpose();
        test_back_to_back();
        test_reset_mid_xfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_state_regfile.md
VEC_STATE_REGFILE -- requirements
Module: vec_state_regfile

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning number of rows; it must be a power of two, a multiple of LANES and at least LANES.
REQ-002 The block SHALL have parameter LANES, default 4, meaning number of elements per row and rows per column/transpose block.
REQ-003 The block SHALL have parameter EW, default 8, meaning element width in bits; row width W = LANES*EW.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have ports rd_addr1 and rd_addr2, input, width log2(DEPTH) each: read row addresses.
REQ-007 The block SHALL have ports col_read, input, width 1, and rd_col, input, width log2(LANES): column-read enable and column index.
REQ-008 The block SHALL have ports wr_en, col_write and wr_addr, inputs, widths 1, 1 and log2(DEPTH): write enable, column-write mode and write base row.
REQ-009 The block SHALL have ports wr_col, input, width log2(LANES); wr_mask, input, width LANES; and wr_data, input, width W: column index, per-element row-write mask and write data.
REQ-010 The block SHALL have ports tr_start, input, width 1, and tr_base, input, width log2(DEPTH): transpose request and block base row.
REQ-011 The block SHALL have ports rd_data1 and rd_data2, output, width W each: read data.
REQ-012 The block SHALL have outputs busy, done and wr_drop, width 1 each: transpose in progress, transpose-complete pulse, and external write rejected.

Function
REQ-013 Element e of a row SHALL occupy bits [W-1-e*EW -: EW], so element 0 is the most significant.
REQ-014 All row-address arithmetic (base+i) SHALL wrap modulo DEPTH.
REQ-015 Reads SHALL be combinational, with no write bypass, so a same-cycle write is visible only after the edge.
REQ-016 With col_read=0, rd_data1 SHALL equal row[rd_addr1] and rd_data2 SHALL equal row[rd_addr2].
REQ-017 With col_read=1, rd_data1 SHALL equal {row[rd_addr1+0].e[rd_col], ..., row[rd_addr1+LANES-1].e[rd_col]}, base row in the MSBs, and rd_data2 SHALL be 0.
REQ-018 A row write (wr_en=1, col_write=0) SHALL write element e of row[wr_addr] from wr_data element e only where wr_mask[e]=1; wr_mask=0 writes nothing.
REQ-019 A column write (wr_en=1, col_write=1) SHALL set row[wr_addr+i].e[wr_col] to wr_data element i for each i in 0..LANES-1; wr_mask is ignored.
REQ-020 The transpose FSM SHALL have states IDLE, XFER and DONE.
REQ-021 In IDLE, on an edge where tr_start=1, the FSM SHALL snapshot rows tr_base..tr_base+LANES-1 into a shadow buffer, latch the base, clear counter k and enter XFER.
REQ-022 In XFER, each edge SHALL write row[base+k] with column k of the snapshot and increment k; after the k=LANES-1 write the FSM SHALL enter DONE.
REQ-023 DONE SHALL last one cycle with done=1 and then return to IDLE; done is otherwise 0.
REQ-024 busy SHALL equal 1 exactly while the state is XFER; transpose latency is LANES+1 cycles from the start edge to done high.
REQ-025 tr_start SHALL be ignored in XFER and DONE, with no queuing.
REQ-026 An external write presented on the start-accept edge or in XFER SHALL be discarded, and wr_drop SHALL be 1 combinationally in that cycle; otherwise wr_drop is 0.
REQ-027 Reads SHALL remain fully functional during a transpose and return partially transposed contents.

Reset
REQ-028 When rst=1 at an edge, all rows, the shadow buffer and k SHALL clear to 0 and the FSM SHALL go to IDLE, including mid-transpose, leaving no partial write.
REQ-029 While rst=1, busy and done SHALL be 0, writes and tr_start SHALL be ignored, and wr_drop SHALL be 0.

Structure
REQ-030 The FSM state enum and the element-index and row-address helper widths SHALL be defined in shared package vec_simd_pkg.
REQ-031 The transpose FSM and shadow buffer SHALL be a single sub-module, vec_state_transposer, and the storage array SHALL remain in the top module.

Verification
REQ-032 The bench SHALL check: reset, then row write 0xA1B2C3D4 to row 5 with mask 1111 -> rd_data1=0xA1B2C3D4 (addr 5) and rd_data2=0 (addr 6).
REQ-033 The bench SHALL check: row 2=0x11223344, masked write 0xFFFFFFFF with mask 0101 -> row 2=0x11FF33FF.
REQ-034 The bench SHALL check: column write 0xDEADBEEF, col 2, base 14 -> byte 2 of rows 14, 15, 0, 1 = DE, AD, BE, EF, and column read col 2, base 14 returns 0xDEADBEEF.
REQ-035 The bench SHALL check: rows 0-3 = 00010203, 04050607, 08090A0B, 0C0D0E0F, tr_start base 0 -> busy for 4 cycles, done on cycle 5, rows = 0004080C, 0105090D, 02060A0E, 03070B0F.
REQ-036 The bench SHALL check: a wr_en during XFER -> wr_drop=1 and the target row is unchanged, and a second tr_start during busy -> ignored.
REQ-037 The bench SHALL check: rst asserted in XFER cycle 2 -> all rows 0, busy=0 and done never pulses.
